// File: rtl/round_robin_fifo_dispatcher_if.sv
// rtl/round_robin_fifo_dispatcher_if.sv - write/read bus bundle for the round-robin FIFO dispatcher
interface round_robin_fifo_dispatcher_if #(
  parameter int WIDTH = 8
);
  logic             wen;
  logic [WIDTH-1:0] din;
  logic             ready;
  logic [3:0]       ren;
  logic [WIDTH-1:0] dout_a;
  logic [WIDTH-1:0] dout_b;
  logic [WIDTH-1:0] dout_c;
  logic [WIDTH-1:0] dout_d;
  logic [3:0]       valid;

  modport master (
    output wen, din, ren,
    input  ready, dout_a, dout_b, dout_c, dout_d, valid
  );

  modport slave (
    input  wen, din, ren,
    output ready, dout_a, dout_b, dout_c, dout_d, valid
  );
endinterface

// File: rtl/round_robin_fifo_dispatcher.sv
// rtl/round_robin_fifo_dispatcher.sv - one writer spread round-robin over four independent FIFOs
module round_robin_fifo_dispatcher #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  round_robin_fifo_dispatcher_if.slave bus
);
  // DEPTH is a power of two, so pointers wrap by plain overflow
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem     [4][DEPTH];
  logic [AW-1:0]    rd_ptr  [4];
  logic [AW-1:0]    wr_ptr  [4];
  logic [CW-1:0]    count   [4];
  logic [WIDTH-1:0] dout_q  [4];
  logic [3:0]       valid_q;
  logic [1:0]       rr;
  logic [3:0]       wr_sel;
  logic [3:0]       rd_sel;
  logic             accept;

  // ready looks only at start-of-cycle occupancy, so a same-cycle read never frees a slot early
  assign bus.ready = (count[rr] != FULL);
  assign accept    = bus.wen & bus.ready;

  // decode which queue takes the write and which queues can serve a read
  always_comb begin
    wr_sel = '0;
    rd_sel = '0;
    for (int i = 0; i < 4; i++) begin
      wr_sel[i] = accept && (rr == 2'(i));
      rd_sel[i] = bus.ren[i] && (count[i] != '0);
    end
  end

  // storage array, deliberately not reset; empty reads never expose it
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst_n && wr_sel[i]) begin
        mem[i][wr_ptr[i]] <= bus.din;
      end
    end
  end

  // pointers, occupancy, round-robin selector and registered read outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr      <= '0;
      valid_q <= '0;
      for (int i = 0; i < 4; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
        dout_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        rr <= rr + 2'd1;
      end
      for (int i = 0; i < 4; i++) begin
        if (wr_sel[i]) begin
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
        end
        if (rd_sel[i]) begin
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
          dout_q[i] <= mem[i][rd_ptr[i]];
        end else begin
          dout_q[i] <= '0;
        end
        valid_q[i] <= rd_sel[i];
        case ({wr_sel[i], rd_sel[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  assign bus.dout_a = dout_q[0];
  assign bus.dout_b = dout_q[1];
  assign bus.dout_c = dout_q[2];
  assign bus.dout_d = dout_q[3];
  assign bus.valid  = valid_q;
endmodule

// File: tb/tb_round_robin_fifo_dispatcher.sv
// tb/tb_round_robin_fifo_dispatcher.sv - randomized bench for round_robin_fifo_dispatcher against a queue model
module tb_round_robin_fifo_dispatcher;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  bit   known;

  logic [WIDTH-1:0] q [4][$];
  int               rr;

  round_robin_fifo_dispatcher_if #(.WIDTH(WIDTH)) bus ();

  round_robin_fifo_dispatcher #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic cycle(input logic w, input logic [WIDTH-1:0] d, input logic [3:0] r, input logic rn);
    logic [WIDTH-1:0] exp_dout [4];
    logic [3:0]       exp_valid;
    logic             exp_ready;
    bus.wen = w;
    bus.din = d;
    bus.ren = r;
    rst_n   = rn;
    @(negedge clk);
    exp_ready = (q[rr].size() < DEPTH);
    if (known) check("ready", bus.ready, exp_ready);
    exp_valid = '0;
    for (int i = 0; i < 4; i++) exp_dout[i] = '0;
    if (!rn) begin
      for (int i = 0; i < 4; i++) q[i].delete();
      rr = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r[i] && q[i].size() > 0) begin
          exp_valid[i] = 1'b1;
          exp_dout[i]  = q[i].pop_front();
        end
      end
      if (w && exp_ready) begin
        q[rr].push_back(d);
        rr = (rr + 1) % 4;
      end
    end
    @(posedge clk);
    #1;
    known = 1'b1;
    check("valid", bus.valid, exp_valid);
    check("dout_a", bus.dout_a, exp_dout[0]);
    check("dout_b", bus.dout_b, exp_dout[1]);
    check("dout_c", bus.dout_c, exp_dout[2]);
    check("dout_d", bus.dout_d, exp_dout[3]);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    known    = 1'b0;
    rr       = 0;
    bus.wen  = 1'b0;
    bus.din  = '0;
    bus.ren  = '0;
    rst_n    = 1'b0;

    repeat (2) cycle(1'b1, 8'd5, 4'hf, 1'b0);
    check("reset_ready", bus.ready, 1'b1);

    // four writes spread one per queue, then read all four together
    cycle(1'b1, 8'd87, 4'h0, 1'b1);
    cycle(1'b1, 8'd56, 4'h0, 1'b1);
    cycle(1'b1, 8'd9,  4'h0, 1'b1);
    cycle(1'b1, 8'd13, 4'h0, 1'b1);
    cycle(1'b0, 8'd0,  4'hf, 1'b1);
    check("t29_valid", bus.valid, 4'b1111);
    check("t29_dout_a", bus.dout_a, 87);
    check("t29_dout_b", bus.dout_b, 56);
    check("t29_dout_c", bus.dout_c, 9);
    check("t29_dout_d", bus.dout_d, 13);
    cycle(1'b0, 8'd0, 4'h0, 1'b1);
    check("t29_idle_valid", bus.valid, 4'b0000);

    // fill every queue, then a held write must be dropped until a frees a slot
    for (int v = 1; v <= 4 * DEPTH; v++) cycle(1'b1, 8'(v), 4'h0, 1'b1);
    check("t30_full_ready", bus.ready, 1'b0);
    repeat (3) cycle(1'b1, 8'd99, 4'h0, 1'b1);
    cycle(1'b0, 8'd0, 4'b0001, 1'b1);
    check("t30_dout_a", bus.dout_a, 1);
    check("t30_ready", bus.ready, 1'b1);
    cycle(1'b1, 8'd99, 4'h0, 1'b1);
    check("t30_ready_after", bus.ready, 1'b0);

    // read of empty c while its first write lands: no forwarding
    cycle(1'b0, 8'd0, 4'h0, 1'b0);
    cycle(1'b1, 8'd11, 4'h0, 1'b1);
    cycle(1'b1, 8'd22, 4'h0, 1'b1);
    cycle(1'b1, 8'd139, 4'b0100, 1'b1);
    check("t31_valid_c", bus.valid[2], 1'b0);
    check("t31_dout_c", bus.dout_c, 0);
    cycle(1'b0, 8'd0, 4'b0100, 1'b1);
    check("t31_dout_c2", bus.dout_c, 139);
    check("t31_valid_c2", bus.valid[2], 1'b1);

    // stream through queue a across several pointer wraps with random reads of a
    cycle(1'b0, 8'd0, 4'h0, 1'b0);
    repeat (3 * DEPTH * 4 + 16) cycle(1'b1, 8'($urandom), {3'b111, 1'($urandom)}, 1'b1);
    repeat (2 * DEPTH) cycle(1'b0, 8'd0, 4'hf, 1'b1);

    // reset with partly filled queues and activity on the same edge
    for (int v = 0; v < 6; v++) cycle(1'b1, 8'(40 + v), 4'h0, 1'b1);
    cycle(1'b1, 8'd55, 4'hf, 1'b0);
    check("t33_valid", bus.valid, 4'b0000);
    check("t33_ready", bus.ready, 1'b1);
    cycle(1'b1, 8'd66, 4'h0, 1'b1);
    cycle(1'b0, 8'd0, 4'b0001, 1'b1);
    check("t33_dout_a", bus.dout_a, 66);
    check("t33_valid_a", bus.valid, 4'b0001);

    // random traffic with occasional resets
    repeat (600) cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom), 1'($urandom_range(0, 63) != 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/round_robin_fifo_dispatcher.md
ROUND_ROBIN_FIFO_DISPATCHER -- requirements
Module: round_robin_fifo_dispatcher

Interface
REQ-001 The block SHALL take a single clock and a synchronous, active-low reset: port clk, port rst_n.
REQ-002 Parameter WIDTH SHALL default to 8 and set the data width.
REQ-003 Parameter DEPTH SHALL default to 8 and set the entries per output queue (power of two).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-006 wen  input  1  write request for din this cycle.
REQ-007 din  input  WIDTH  write data.
REQ-008 ready  output  1  combinational; 1 when the queue selected by the round-robin pointer is not full.
REQ-009 ren  input  4  per-queue read request; bit0=a, bit1=b, bit2=c, bit3=d.
REQ-010 dout_a, dout_b, dout_c, dout_d  output  WIDTH each  registered read data per queue.
REQ-011 valid  output  4  registered; valid[i] qualifies the matching dout for one cycle.

Function
REQ-012 The block SHALL contain four independent circular FIFOs (a,b,c,d), each DEPTH x WIDTH, with read pointer, write pointer and occupancy counter (0..DEPTH).
REQ-013 A 2-bit round-robin pointer SHALL select the target queue for the next write: order a->b->c->d->a.
REQ-014 On wen=1 and ready=1, din SHALL be stored at the tail of the target queue and the pointer SHALL advance by one (d wraps to a).
REQ-015 On wen=1 and ready=0, the write SHALL be dropped, no queue state SHALL change, and the pointer SHALL NOT advance (writer holds data and retries).
REQ-016 On wen=0 the pointer SHALL hold.
REQ-017 ready SHALL depend only on the target queue occupancy at the start of the cycle; a same-cycle read of that full queue SHALL NOT make ready=1.
REQ-018 On ren[i]=1 with queue i non-empty, the head entry SHALL appear on dout_i at the next rising edge with valid[i]=1, and the read pointer SHALL advance.
REQ-019 On ren[i]=1 with queue i empty, the next cycle SHALL have valid[i]=0 and dout_i=0; a same-cycle write into queue i SHALL NOT be forwarded.
REQ-020 On ren[i]=0, the next cycle SHALL have valid[i]=0 and dout_i=0.
REQ-021 Read latency SHALL be exactly one cycle; all four queues SHALL be readable in the same cycle.
REQ-022 A simultaneous accepted write and successful read on the same queue SHALL both complete; occupancy unchanged.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; data order within each queue SHALL be preserved across wrap.
REQ-024 Occupancy SHALL never exceed DEPTH nor go below 0.

Reset
REQ-025 While rst_n=0 at a rising edge: all queue pointers and counters SHALL clear to 0, round-robin pointer SHALL select queue a, valid SHALL be 4'b0000, all dout SHALL be 0.
REQ-026 Reset SHALL override any same-cycle wen or ren; data accepted before reset is discarded.
REQ-027 Memory array contents SHALL NOT require reset; no unwritten entry SHALL ever be visible on dout.

Verification
REQ-028 Reset, then wen=1 for 4 cycles with din=87,56,9,13 -> queues a,b,c,d each hold one entry; ready=1 throughout; pointer back at a.
REQ-029 After REQ-028, ren=4'b1111 one cycle -> next cycle valid=4'b1111, dout_a=87, dout_b=56, dout_c=9, dout_d=13; following cycle with ren=0 -> valid=0, all dout=0.
REQ-030 Write 4*DEPTH=32 values 1..32 -> every queue full, ready=0; 33rd write value 99 held for 3 cycles -> dropped, pointer stays at a; then ren[0]=1 one cycle -> dout_a=1 and ready=1 next cycle; write accepted into a.
REQ-031 Read empty queue c (ren=4'b0100) while writing din=139 that lands in c -> next cycle valid[2]=0, dout_c=0; ren=4'b0100 again -> dout_c=139, valid[2]=1.
REQ-032 Drive queue a through 3*DEPTH writes interleaved with reads (writes only land on a every 4th accepted write) -> dout_a sequence matches write order across pointer wrap, no loss.
REQ-033 Assert rst_n=0 for one cycle with queues partly filled and ren=4'b1111, wen=1 -> next cycle valid=0, all dout=0, ready=1, next write lands in a.
